// File: rtl/gpo_multi_core.sv
// Multi-channel timed GPO core: timestamp-matched events are applied per channel under a mask,
// with a pending-event FIFO during downstream busy. Optional macro GPO_STICKY_ERR_EN latches the first overflow.
module gpo_multi_core #(
    parameter int NUM_CH     = 4,
    parameter int DATA_WIDTH = 64,
    parameter int BUF_DEPTH  = 4
) (
    input  logic                                  CLK100MHZ,
    input  logic                                  reset,
    input  logic                                  counter_matched,
    input  logic [NUM_CH*DATA_WIDTH-1:0]          gpo_in,
    input  logic [NUM_CH-1:0]                     ch_mask,
    input  logic [NUM_CH-1:0]                     override_en,
    input  logic [NUM_CH*DATA_WIDTH-1:0]          override_value,
    input  logic                                  busy,
    output logic                                  selected,
    output logic [NUM_CH-1:0]                     overrided,
    output logic [$clog2(BUF_DEPTH+1)-1:0]        buf_level,
    output logic                                  overflow_error,
    output logic [NUM_CH+NUM_CH*DATA_WIDTH-1:0]   error_data,
    output logic [NUM_CH*DATA_WIDTH-1:0]          gpo_out
);

    localparam int WORD_W  = NUM_CH * DATA_WIDTH;
    localparam int ENTRY_W = NUM_CH + WORD_W;
    localparam int PTR_W   = $clog2(BUF_DEPTH);
    localparam int LVL_W   = $clog2(BUF_DEPTH + 1);

    logic [ENTRY_W-1:0] r_fifo [BUF_DEPTH];
    logic [PTR_W-1:0]   r_wrPtr;
    logic [PTR_W-1:0]   r_rdPtr;
    logic [LVL_W-1:0]   r_level;
    logic [WORD_W-1:0]  r_shadow;
    logic [WORD_W-1:0]  r_ovrReg;
    logic [NUM_CH-1:0]  r_ovrState;

    logic               w_empty;
    logic               w_full;
    logic               w_bypass;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;
    logic               w_apply;
    logic [ENTRY_W-1:0] w_incoming;
    logic [ENTRY_W-1:0] w_applyEntry;
    logic [NUM_CH-1:0]  w_applyMask;
    logic [WORD_W-1:0]  w_applyData;

    // A pop frees a slot in the same cycle, so a match at full is only dropped when nothing drains.
    always_comb begin
        w_incoming   = {ch_mask, gpo_in};
        w_empty      = (r_level == '0);
        w_full       = (r_level == LVL_W'(BUF_DEPTH));
        w_bypass     = counter_matched && w_empty && !busy;
        w_pop        = !busy && !w_empty;
        w_drop       = counter_matched && w_full && !w_pop;
        w_push       = counter_matched && !w_bypass && !w_drop;
        w_apply      = w_bypass || w_pop;
        w_applyEntry = w_pop ? r_fifo[r_rdPtr] : w_incoming;
        w_applyMask  = w_applyEntry[ENTRY_W-1:WORD_W];
        w_applyData  = w_applyEntry[WORD_W-1:0];
    end

    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                r_fifo[i] <= '0;
            end
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_fifo[r_wrPtr] <= w_incoming;
                r_wrPtr         <= r_wrPtr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            r_shadow   <= '0;
            r_ovrReg   <= '0;
            r_ovrState <= '0;
            selected   <= 1'b0;
            overrided  <= '0;
        end else begin
            selected  <= w_apply;
            overrided <= w_apply ? (w_applyMask & r_ovrState) : '0;
            for (int k = 0; k < NUM_CH; k++) begin
                if (w_apply && w_applyMask[k]) begin
                    r_shadow[k*DATA_WIDTH +: DATA_WIDTH] <= w_applyData[k*DATA_WIDTH +: DATA_WIDTH];
                end
                if (!busy && override_en[k]) begin
                    r_ovrReg[k*DATA_WIDTH +: DATA_WIDTH] <= override_value[k*DATA_WIDTH +: DATA_WIDTH];
                end
            end
            if (!busy) begin
                r_ovrState <= override_en;
            end
        end
    end

    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            overflow_error <= 1'b0;
            error_data     <= '0;
        end else begin
`ifdef GPO_STICKY_ERR_EN
            if (w_drop && !overflow_error) begin
                overflow_error <= 1'b1;
                error_data     <= w_incoming;
            end
`else
            overflow_error <= w_drop;
            if (w_drop) begin
                error_data <= w_incoming;
            end
`endif
        end
    end

    always_comb begin
        buf_level = r_level;
        gpo_out   = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            gpo_out[k*DATA_WIDTH +: DATA_WIDTH] = r_ovrState[k] ? r_ovrReg[k*DATA_WIDTH +: DATA_WIDTH]
                                                                : r_shadow[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

endmodule
